// File: rtl/uart_program_loader.sv
// Loads a framed program (sync, count, payload, XOR checksum) from UART bytes into
// instruction memory and answers each frame with an ACK/NAK byte.
module uart_program_loader #(
    parameter int unsigned WordBytes  = 7,
    parameter int unsigned AddrW      = 8,
    parameter int unsigned TimeoutCyc = 60000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_byte_i,
    input  logic                   tx_busy_i,
    output logic                   tx_start_o,
    output logic [7:0]             tx_byte_o,
    output logic                   mem_we_o,
    output logic [AddrW-1:0]       mem_addr_o,
    output logic [8*WordBytes-1:0] mem_wdata_o,
    output logic                   busy_o,
    output logic                   load_done_o,
    output logic                   load_error_o,
    output logic [7:0]             prog_len_o
);

    localparam int unsigned DataW = 8 * WordBytes;
    localparam int unsigned IdxW  = $clog2(WordBytes);
    localparam int unsigned TmoW  = $clog2(TimeoutCyc);

    localparam logic [IdxW-1:0] LastByte = IdxW'(WordBytes - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TimeoutCyc - 1);
    localparam logic [7:0]      SyncByte = 8'hA5;
    localparam logic [7:0]      AckByte  = 8'h06;
    localparam logic [7:0]      NakByte  = 8'h15;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCount = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       chk_q, chk_d;
    logic [IdxW-1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]       word_idx_q, word_idx_d;
    logic [DataW-1:0] acc_q, acc_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             mem_we_q, mem_we_d;
    logic [AddrW-1:0] mem_addr_q, mem_addr_d;
    logic [DataW-1:0] mem_wdata_q, mem_wdata_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
    logic [7:0]       prog_len_q, prog_len_d;

    logic in_frame;
    logic all_written;
    logic chk_byte;
    logic timed_out;

    assign in_frame    = (state_q == StCount) || (state_q == StData) || (state_q == StCheck);
    assign all_written = (word_idx_q == count_q);
    // The checksum byte may arrive in the same cycle the final write is issued.
    assign chk_byte    = rx_valid_i &&
                         ((state_q == StCheck) || ((state_q == StData) && all_written));
    assign timed_out   = in_frame && !rx_valid_i && (tmo_q == TmoLast);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        chk_d        = chk_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        acc_d        = acc_q;
        tx_byte_d    = tx_byte_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        prog_len_d   = prog_len_q;
        tmo_d        = tmo_q + 1'b1;

        if (rx_valid_i || !in_frame) begin
            tmo_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (rx_valid_i && (rx_byte_i == SyncByte)) begin
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    chk_d        = '0;
                    byte_idx_d   = '0;
                    word_idx_d   = '0;
                    acc_d        = '0;
                    state_d      = StCount;
                end
            end
            StCount: begin
                if (rx_valid_i) begin
                    if (rx_byte_i == 8'h00) begin
                        tx_byte_d    = NakByte;
                        load_error_d = 1'b1;
                        state_d      = StResp;
                    end else begin
                        count_d = rx_byte_i;
                        chk_d   = rx_byte_i;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (all_written) begin
                    state_d = StCheck;
                end else if (rx_valid_i) begin
                    acc_d[8*byte_idx_q +: 8] = rx_byte_i;
                    chk_d                    = chk_q ^ rx_byte_i;
                    if (byte_idx_q == LastByte) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = AddrW'(word_idx_q);
                        mem_wdata_d = acc_d;
                        byte_idx_d  = '0;
                        word_idx_d  = word_idx_q + 8'd1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            StCheck: ;
            StResp: begin
                if (!tx_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (chk_byte) begin
            if (rx_byte_i == chk_q) begin
                tx_byte_d   = AckByte;
                load_done_d = 1'b1;
                prog_len_d  = count_q;
            end else begin
                tx_byte_d    = NakByte;
                load_error_d = 1'b1;
            end
            state_d = StResp;
        end

        if (timed_out) begin
            tx_byte_d    = NakByte;
            load_error_d = 1'b1;
            state_d      = StResp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            count_q      <= '0;
            chk_q        <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            acc_q        <= '0;
            tmo_q        <= '0;
            tx_byte_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            prog_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            chk_q        <= chk_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            acc_q        <= acc_d;
            tmo_q        <= tmo_d;
            tx_byte_q    <= tx_byte_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            prog_len_q   <= prog_len_d;
        end
    end

    // tx_byte is already settled when RESP is entered, so the strobe can follow tx_busy directly.
    assign tx_start_o   = (state_q == StResp) && !tx_busy_i;
    assign tx_byte_o    = tx_byte_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = (state_q != StIdle);
    assign load_done_o  = load_done_q;
    assign load_error_o = load_error_q;
    assign prog_len_o   = prog_len_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected writes and responses are queued as
// frames are sent and popped as the DUT emits mem_we / tx_start.
module tb_uart_program_loader;

    localparam int unsigned WordBytes  = 7;
    localparam int unsigned AddrW      = 8;
    localparam int unsigned TimeoutCyc = 300;

    typedef struct {
        logic [7:0]  addr;
        logic [55:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [55:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [7:0]  prog_len;

    int errors = 0;
    int checks = 0;
    int tx_seen = 0;
    int wr_seen = 0;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    uart_program_loader #(
        .WordBytes (WordBytes),
        .AddrW     (AddrW),
        .TimeoutCyc(TimeoutCyc)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_byte_i   (rx_byte),
        .tx_busy_i   (tx_busy),
        .tx_start_o  (tx_start),
        .tx_byte_o   (tx_byte),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .busy_o      (busy),
        .load_done_o (load_done),
        .load_error_o(load_error),
        .prog_len_o  (prog_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: outputs are observed at the falling edge, inputs change just after the rise.
    task automatic step();
        wr_t w;
        @(negedge clk);
        if (mem_we) begin
            wr_seen++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL mem_write_unexpected: got addr %0h data %0h, required none",
                         mem_addr, mem_wdata);
            end else begin
                w = exp_wr.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                    errors++;
                    $display("FAIL mem_write: got addr %0h data %0h, required addr %0h data %0h",
                             mem_addr, mem_wdata, w.addr, w.data);
                end
            end
        end
        if (tx_start) begin
            tx_seen++;
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %0h, required none", tx_byte);
            end else if (tx_byte !== exp_tx[0]) begin
                errors++;
                $display("FAIL tx_byte: got %0h, required %0h", tx_byte, exp_tx[0]);
                void'(exp_tx.pop_front());
            end else begin
                void'(exp_tx.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    // Sends a full frame with random payload; queues the writes and the response it implies.
    task automatic send_frame(input int cnt, input bit good, input int gap);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [55:0] w;
        logic [7:0]  bytes[WordBytes];
        wr_t         e;
        send_byte(8'hA5, gap);
        send_byte(8'(cnt), gap);
        chk = 8'(cnt);
        for (int wi = 0; wi < cnt; wi++) begin
            w = '0;
            for (int k = 0; k < WordBytes; k++) begin
                b          = 8'($urandom_range(0, 255));
                bytes[k]   = b;
                w[8*k +: 8] = b;
                chk        = chk ^ b;
            end
            e.addr = 8'(wi);
            e.data = w;
            exp_wr.push_back(e);
            for (int k = 0; k < WordBytes; k++) send_byte(bytes[k], gap);
        end
        exp_tx.push_back(good ? 8'h06 : 8'h15);
        send_byte(good ? chk : (chk ^ 8'h5A), gap);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d tx and %0d writes outstanding, required 0",
                     name, exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
    endtask

    task automatic check_flags(input string name, input logic done, input logic err,
                               input logic [7:0] len);
        checks++;
        if (load_done !== done || load_error !== err || prog_len !== len || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: got done=%b err=%b len=%0d busy=%b, required %b %b %0d 0",
                     name, load_done, load_error, prog_len, busy, done, err, len);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({tx_start, tx_byte, mem_we, mem_addr, mem_wdata, busy, load_done, load_error,
             prog_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero (busy=%b done=%b len=%0d), required all 0",
                     busy, load_done, prog_len);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] pl[9];
        wr_t e;
        pl = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h01};
        e.addr = 8'h00;
        e.data = 56'h77665544332211;
        exp_wr.push_back(e);
        exp_tx.push_back(8'h06);
        send_byte(8'hA5, 3);
        for (int i = 0; i < 9; i++) send_byte(pl[i], 3);
        drain("good_frame", 20);
        check_flags("good_frame", 1'b1, 1'b0, 8'd1);
        checks++;
        if (tx_byte !== 8'h06) begin
            errors++;
            $display("FAIL tx_byte_hold: got %0h, required 06", tx_byte);
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(2, 1'b0, 2);
        drain("bad_chk", 20);
        check_flags("bad_chk", 1'b0, 1'b1, 8'd1);
    endtask

    task automatic test_zero_count();
        int w0 = wr_seen;
        exp_tx.push_back(8'h15);
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        drain("zero_count", 20);
        check_flags("zero_count", 1'b0, 1'b1, 8'd1);
        checks++;
        if (wr_seen != w0) begin
            errors++;
            $display("FAIL zero_count_writes: got %0d, required 0", wr_seen - w0);
        end
    endtask

    task automatic test_timeout();
        int w0 = wr_seen;
        send_byte(8'hA5, 2);
        send_byte(8'h03, 2);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 2);
        exp_tx.push_back(8'h15);
        repeat (TimeoutCyc - 20) step();
        checks++;
        if (busy !== 1'b1 || exp_tx.size() != 1) begin
            errors++;
            $display("FAIL timeout_early: got busy=%b pending=%0d, required busy=1 pending=1",
                     busy, exp_tx.size());
        end
        repeat (40) step();
        drain("timeout", 5);
        check_flags("timeout", 1'b0, 1'b1, 8'd1);
        checks++;
        if (wr_seen != w0) begin
            errors++;
            $display("FAIL timeout_writes: got %0d, required 0", wr_seen - w0);
        end
    endtask

    task automatic test_tx_busy();
        int t0;
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got busy=%b, required 0", busy);
        end
        tx_busy = 1'b1;
        t0 = tx_seen;
        send_frame(1, 1'b1, 3);
        repeat (100) step();
        checks++;
        if (tx_seen != t0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tx_busy_hold: got tx=%0d busy=%b, required tx=0 busy=1",
                     tx_seen - t0, busy);
        end
        tx_busy = 1'b0;
        step();
        checks++;
        if (tx_seen != t0 + 1) begin
            errors++;
            $display("FAIL tx_busy_release: got tx=%0d, required 1", tx_seen - t0);
        end
        drain("tx_busy", 5);
        check_flags("tx_busy", 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_max_count();
        send_frame(255, 1'b1, 1);
        drain("max_count", 20);
        check_flags("max_count", 1'b1, 1'b0, 8'd255);
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        int w0;
        send_byte(8'hA5, 2);
        send_byte(8'h02, 2);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h90 + i), 2);
        t0 = tx_seen;
        w0 = wr_seen;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({tx_start, tx_byte, mem_we, mem_addr, mem_wdata, busy, load_done, load_error,
             prog_len} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b len=%0d, required all 0",
                     busy, load_done, prog_len);
        end
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 2);
        repeat (20) step();
        checks++;
        if (tx_seen != t0 || wr_seen != w0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got tx=%0d writes=%0d, required 0 0",
                     tx_seen - t0, wr_seen - w0);
        end
        send_frame(2, 1'b1, 2);
        drain("after_reset", 20);
        check_flags("after_reset", 1'b1, 1'b0, 8'd2);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = '0;
        tx_busy  = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_count();
        test_timeout();
        test_tx_busy();
        test_max_count();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
